// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/module_hex7seg.sv
// Combinational hex nibble to active-low segment decoder.
// Pure table lookup; no state.
module module_hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/module_display_scan.sv
// Time-multiplexed N-digit 7-segment scan controller.
// Blanks each slot start; new values land only on frame edges.
module module_display_scan
  import display_pkg::*;
#(
  parameter int FREQ_IN       = 27_000_000,
  parameter int SCAN_HZ       = 1_000,
  parameter int N_DIGITS      = 4,
  parameter int BLANK_CYCLES  = 270,
  parameter bit ACTIVE_LOW_AN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_done_o
);

  localparam int SLOT_CYCLES = FREQ_IN / SCAN_HZ;
  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(N_DIGITS - 1);

  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{ACTIVE_LOW_AN}};

  if (!(BLANK_CYCLES > 0 && BLANK_CYCLES < SLOT_CYCLES)) begin : g_bad_blank
    $error("BLANK_CYCLES must lie strictly between 0 and SLOT_CYCLES");
  end

  scan_state_t state;
  scan_state_t nxt_state;

  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt_cnt;
  logic [DW-1:0] digit;
  logic [DW-1:0] nxt_digit;

  logic                  pending;
  logic [4*N_DIGITS-1:0] buf_data;
  logic [N_DIGITS-1:0]   buf_dp;
  logic [4*N_DIGITS-1:0] disp_data;
  logic [N_DIGITS-1:0]   disp_dp;

  logic                boundary;
  logic                accept;
  logic [3:0]          nib;
  logic                nib_dp;
  logic [6:0]          seg_dec;
  logic [N_DIGITS-1:0] an_sel;

  assign data_ready_o = !pending;
  assign accept       = data_valid_i && !pending;

  assign boundary = enable_i
                 && (state != IDLE)
                 && (cnt == SLOT_LAST)
                 && (digit == DIGIT_LAST);

  assign an_sel = AN_OFF ^ (N_DIGITS'(1) << nxt_digit);

  // Next scan position: slot counter, digit index and phase.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_digit = digit;
    if (!enable_i) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_digit = '0;
    end else if (state == IDLE) begin
      nxt_state = BLANK;
      nxt_cnt   = '0;
      nxt_digit = '0;
    end else if (cnt == SLOT_LAST) begin
      nxt_state = BLANK;
      nxt_cnt   = '0;
      nxt_digit = (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
    end else begin
      nxt_cnt = cnt + 1'b1;
      if (cnt == BLANK_LAST) begin
        nxt_state = DRIVE;
      end
    end
  end

  // Pick the nibble and point for the digit about to be shown.
  always_comb begin
    nib    = '0;
    nib_dp = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (nxt_digit == DW'(k)) begin
        nib    = disp_data[4*k +: 4];
        nib_dp = disp_dp[k];
      end
    end
  end

  module_hex7seg u_hex7seg (
    .nibble (nib),
    .seg    (seg_dec)
  );

  // Scan FSM; outputs follow the state being entered on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      digit        <= '0;
      an_o         <= AN_OFF;
      seg_o        <= SEG_OFF;
      dp_o         <= 1'b1;
      frame_done_o <= 1'b0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      digit        <= nxt_digit;
      frame_done_o <= boundary;
      if (nxt_state == DRIVE) begin
        an_o  <= an_sel;
        seg_o <= seg_dec;
        dp_o  <= ~nib_dp;
      end else begin
        an_o  <= AN_OFF;
        seg_o <= SEG_OFF;
        dp_o  <= 1'b1;
      end
    end
  end

  // One-entry input buffer, drained into the display only at frame edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      buf_data  <= '0;
      buf_dp    <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else if (boundary && pending) begin
      disp_data <= buf_data;
      disp_dp   <= buf_dp;
      pending   <= 1'b0;
    end else if (accept) begin
      buf_data <= data_i;
      buf_dp   <= dp_i;
      pending  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_module_display_scan.sv
// Scoreboard bench for module_display_scan (10-cycle slots, 2 blank).
// Expected slots and frame pulses are queued; a monitor pops and compares.
module tb_module_display_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_done_o;

  module_display_scan #(
    .FREQ_IN       (100),
    .SCAN_HZ       (10),
    .N_DIGITS      (4),
    .BLANK_CYCLES  (2),
    .ACTIVE_LOW_AN (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .data_i       (data_i),
    .dp_i         (dp_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .an_o         (an_o),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t exp_q[$];
  int    fd_q[$];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    e0, e1, e2;
  int    drv_len = 0;
  logic [3:0] prev_an = 4'hF;
  slot_t mon_e;
  int    mon_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpn);
    exp_q.push_back('{an: 4'hE, seg: s0, dp: ~dpn[0]});
    exp_q.push_back('{an: 4'hD, seg: s1, dp: ~dpn[1]});
    exp_q.push_back('{an: 4'hB, seg: s2, dp: ~dpn[2]});
    exp_q.push_back('{an: 4'h7, seg: s3, dp: ~dpn[3]});
  endtask

  task automatic chk_off(input string name);
    chk({name, "_an"}, 32'(an_o), 32'hF);
    chk({name, "_seg"}, 32'(seg_o), 32'h7F);
    chk({name, "_dp"}, 32'(dp_o), 32'h1);
    chk({name, "_fd"}, 32'(frame_done_o), 32'h0);
  endtask

  // Monitor: slot contents at every drive start, drive length, frame pulses.
  always @(negedge clk) begin
    if (an_o != 4'hF) begin
      if (prev_an == 4'hF) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_drive: got an %0h, expected none", an_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("slot_an", 32'(an_o), 32'(mon_e.an));
          chk("slot_seg", 32'(seg_o), 32'(mon_e.seg));
          chk("slot_dp", 32'(dp_o), 32'(mon_e.dp));
        end
        drv_len = 1;
      end else begin
        drv_len++;
      end
    end else if (prev_an != 4'hF && rst_n && enable_i) begin
      chk("drive_len", drv_len, 8);
    end
    prev_an = an_o;
    if (frame_done_o) begin
      if (fd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: got pulse at %0d, expected none",
                 cyc);
      end else begin
        mon_c = fd_q.pop_front();
        chk("frame_done_cycle", cyc, mon_c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    enable_i     = 1'b0;
    data_valid_i = 1'b0;
    data_i       = 16'h0000;
    dp_i         = 4'h0;
    step();
    step();
    chk_off("reset");
    chk("reset_ready", 32'(data_ready_o), 32'h1);
    rst_n = 1'b1;
    step();

    // Start scanning, load a value, then reset in the middle of DRIVE.
    e0 = cyc;
    exp_q.push_back('{an: 4'hE, seg: 7'h40, dp: 1'b1});
    enable_i = 1'b1;
    step_to(e0 + 3);
    chk("first_drive_an", 32'(an_o), 32'hE);
    data_valid_i = 1'b1;
    data_i       = 16'hFFFF;
    dp_i         = 4'hF;
    step();
    chk("pre_reset_ready", 32'(data_ready_o), 32'h0);
    data_valid_i = 1'b0;
    step();
    rst_n    = 1'b0;
    enable_i = 1'b0;
    #1;
    chk_off("mid_reset");
    chk("mid_reset_ready", 32'(data_ready_o), 32'h1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Main run: frames 1..5 full, frame 6 only its first slot.
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0001);
    push_frame(7'h21, 7'h46, 7'h03, 7'h08, 4'b1000);
    push_frame(7'h00, 7'h78, 7'h02, 7'h12, 4'b0110);
    push_frame(7'h00, 7'h78, 7'h02, 7'h12, 4'b0110);
    exp_q.push_back('{an: 4'hE, seg: 7'h40, dp: 1'b1});
    e1 = cyc;
    for (int f = 1; f <= 5; f++) fd_q.push_back(e1 + 40 * f + 1);
    enable_i = 1'b1;
    step();
    chk("blank0_an", 32'(an_o), 32'hF);
    step();
    chk("blank1_an", 32'(an_o), 32'hF);
    step();
    chk("drive0_an", 32'(an_o), 32'hE);

    // Mid-frame handshake.
    step_to(e1 + 10);
    data_valid_i = 1'b1;
    data_i       = 16'h1234;
    dp_i         = 4'b0001;
    step();
    chk("accept_ready", 32'(data_ready_o), 32'h0);
    data_valid_i = 1'b0;
    step_to(e1 + 40);
    chk("boundary_ready", 32'(data_ready_o), 32'h0);
    step();
    chk("release_ready", 32'(data_ready_o), 32'h1);
    chk("release_fd", 32'(frame_done_o), 32'h1);

    // Back-pressure: second item waits for the next boundary.
    step_to(e1 + 45);
    data_valid_i = 1'b1;
    data_i       = 16'hABCD;
    dp_i         = 4'b1000;
    step();
    chk("bp_first_accept", 32'(data_ready_o), 32'h0);
    data_i = 16'h5678;
    dp_i   = 4'b0110;
    step_to(e1 + 60);
    chk("bp_held", 32'(data_ready_o), 32'h0);
    step_to(e1 + 81);
    chk("bp_ready_after_fd", 32'(data_ready_o), 32'h1);
    step();
    chk("bp_late_accept", 32'(data_ready_o), 32'h0);
    data_valid_i = 1'b0;

    // Valid exactly on a boundary cycle with an empty buffer.
    step_to(e1 + 160);
    data_valid_i = 1'b1;
    data_i       = 16'h9EF0;
    dp_i         = 4'b0100;
    step();
    chk("coin_fd", 32'(frame_done_o), 32'h1);
    chk("coin_ready", 32'(data_ready_o), 32'h0);
    data_valid_i = 1'b0;

    // Drop enable mid-DRIVE; handshake still runs while idle.
    step_to(e1 + 205);
    enable_i = 1'b0;
    step();
    chk_off("disable");
    step_to(e1 + 207);
    data_valid_i = 1'b1;
    data_i       = 16'h4321;
    dp_i         = 4'b0000;
    step();
    chk("idle_accept", 32'(data_ready_o), 32'h0);
    data_valid_i = 1'b0;
    step_to(e1 + 210);

    // Re-enable: restarts at digit 0 after a blank interval.
    push_frame(7'h40, 7'h0E, 7'h06, 7'h10, 4'b0100);
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'b0000);
    e2 = cyc;
    fd_q.push_back(e2 + 41);
    fd_q.push_back(e2 + 81);
    enable_i = 1'b1;
    step();
    chk("reen_blank0", 32'(an_o), 32'hF);
    step();
    chk("reen_blank1", 32'(an_o), 32'hF);
    step();
    chk("reen_drive0", 32'(an_o), 32'hE);
    step_to(e2 + 82);
    enable_i = 1'b0;
    step_to(e2 + 90);

    chk("slots_left", exp_q.size(), 0);
    chk("frames_left", fd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
